serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Serial bit-stream pattern transmitter: accepts a job (pattern, length, repetition count, inter-repetition gap) through a valid/ready handshake and emits the pattern MSB-first, one bit per clock, with a qualifying valid strobe. It is the transmit-side counterpart of the shift-register sequence detectors in the FSM exercise set. Its out_bit drives a detector's new_bit directly, so it serves as both a reusable stimulus source for those benches and a serial-link TX block.

## Interface
- MAX_W, 8, maximum pattern length in bits
- LEN_W, $clog2(MAX_W)+1, width of len
- CNT_W, 4, width of reps
- GAP_W, 4, width of gap
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_valid  in  1  job request
- start_ready  out  1  block can accept a job (high only in IDLE)
- pattern  in  MAX_W  pattern bits, sent from pattern[len-1] down to pattern[0]
- len  in  LEN_W  pattern length; 0 means no-op, values above MAX_W clamp to MAX_W
- reps  in  CNT_W  repetition count; 0 means no-op
- gap  in  GAP_W  idle cycles between repetitions (not after the last)
- abort  in  1  synchronous cancel of the running job
- out_bit  out  1  serial data, forced 0 when out_valid low
- out_valid  out  1  out_bit carries pattern data this cycle
- done  out  1  one-cycle pulse on job completion (normal or aborted)

## Operation
- FSM states IDLE, SEND, GAP (enum in package).
- IDLE: start_ready=1. On start_valid: latch pattern, clamped len, reps, gap.
  - len==0 or reps==0: stay IDLE, pulse done next cycle.
  - Otherwise go to SEND with bit index = len-1 and rep counter = reps.
- SEND: out_valid=1, out_bit=pattern[idx]; idx decrements each cycle. After idx 0:
  - Final repetition: go to IDLE and pulse done.
  - Else gap>0: go to GAP, decrement rep counter, load gap counter.
  - Else gap==0: reload idx = len-1 and stay in SEND, giving back-to-back repetitions.
- GAP: out_valid=0, out_bit=0 for exactly gap cycles, then reload idx and go to SEND.
- abort high in SEND or GAP: next cycle IDLE, out_valid=0, done pulses. abort in IDLE ignored; start is accepted normally.
- Inputs other than start_valid and abort are sampled only on the accept edge; later changes have no effect on the job in flight.

## Timing
- Async reset: state=IDLE, out_bit=0, out_valid=0, done=0, start_ready=1. Reset takes effect immediately, including mid-job. No done pulse for a job killed by reset.
- All outputs are registered except start_ready, which is decoded from state.
- Job accepted at edge k with len=L, reps=R, gap=G, R,L>0:
  - First bit valid in cycle k+1.
  - Total busy span = R·L + (R-1)·G cycles.
  - done and start_ready high in the cycle after the final bit.
- No-op job at edge k: done in cycle k+1; start_ready stays 1.
- Minimum spacing between job accepts: one cycle after done.
- abort sampled at edge m: out_valid low from cycle m+1, done in cycle m+1.

## Structure
- Package serial_pattern_pkg holds:
  - state_t enum (IDLE, SEND, GAP)
  - default width localparams (MAX_W, CNT_W, GAP_W)
  - clamp function for len
- One natural sub-module: pattern_shifter, a parallel-load, MSB-first shifter with a bit-index down counter and a last flag. The FSM and the rep/gap counters stay in the top.

## Test plan
- pattern=6'b110011, len=6, reps=1, gap=0, fed into the 6-bit detector:
  - out_bit 1,1,0,0,1,1 in cycles k+1..k+6.
  - detected high in cycle k+7; done and start_ready high in k+7.
- pattern=4'b1010, len=4, reps=3, gap=2:
  - Stream 1010,gap,1010,gap,1010 over 16 cycles; out_valid low exactly in the 4 gap cycles.
  - The 4-bit detector fires once after each repetition; done in cycle k+17.
- reps=0, then len=0:
  - No out_valid at any point; done pulses in k+1 each time; start_ready never drops.
- pattern=8'hA5, len=8, reps=2; abort asserted at the 3rd bit of rep 1:
  - out_valid low from the next cycle; done pulses once; a new job is accepted on the following edge.
- len=9 with MAX_W=8: exactly 8 bits emitted.
- rst pulled low mid-GAP: all outputs 0 immediately; after release, a new job runs correctly from IDLE.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// serial_pattern_pkg: shared widths, FSM state type and pattern-length clamp
package serial_pattern_pkg;

    localparam int MAX_W = 8;
    localparam int LEN_W = $clog2(MAX_W) + 1;
    localparam int CNT_W = 4;
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Lengths beyond the pattern register simply send the whole register
    function automatic int clamp_len(input int l, input int m);
        return (l > m) ? m : l;
    endfunction

endpackage

// File: rtl/serial_pattern_gen_shifter.sv
// pattern_shifter: parallel-load MSB-first shifter with bit-index countdown and last flag
module pattern_shifter #(
    parameter int MAX_W = 8,
    parameter int LEN_W = $clog2(MAX_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic             clear,
    input  logic [MAX_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             msb,
    output logic             last
);
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_W);

    logic [MAX_W-1:0] pat, sh;
    logic [LEN_W-1:0] ln, idx;

    // Left-justified data drains to zero after len shifts, so msb is already 0 whenever nothing is being sent
    assign msb  = sh[MAX_W-1];
    assign last = idx == '0;

    // Priority: clear, load a new job, restart the stored pattern, shift
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pat <= '0;
            ln  <= '0;
            sh  <= '0;
            idx <= '0;
        end else if (clear) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            pat <= pattern;
            ln  <= len;
            sh  <= pattern << (FULL - len);
            idx <= len - 1'b1;
        end else if (reload) begin
            sh  <= pat << (FULL - ln);
            idx <= ln - 1'b1;
        end else if (shift) begin
            sh  <= sh << 1;
            idx <= idx - 1'b1;
        end

endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: valid/ready job-driven serial pattern transmitter, MSB first
module serial_pattern_gen
    import serial_pattern_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [MAX_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done
);
    state_t           state, state_n;
    logic [CNT_W-1:0] rep;
    logic [GAP_W-1:0] gap_r, gcnt;
    logic [LEN_W-1:0] len_c;
    logic             last, accept, go, kill, last_bit, fin, to_gap, b2b, gap_end;

    assign len_c       = LEN_W'(clamp_len(int'(len), MAX_W));
    assign start_ready = state == IDLE;
    assign accept      = start_ready && start_valid;
    assign go          = accept && len_c != '0 && reps != '0;
    assign kill        = abort && !start_ready;
    assign last_bit    = state == SEND && last;
    assign fin         = last_bit && rep == CNT_W'(1);
    assign to_gap      = last_bit && !fin && gap_r != '0;
    assign b2b         = last_bit && !fin && gap_r == '0;
    assign gap_end     = state == GAP && gcnt == GAP_W'(1);

    // Next state: abort wins, then job accept, end of repetition, end of gap
    always_comb
        state_n = kill ? IDLE :
                  start_ready ? (go ? SEND : IDLE) :
                  state == SEND ? (fin ? IDLE : to_gap ? GAP : SEND) :
                  (gap_end ? SEND : GAP);

    pattern_shifter #(.MAX_W(MAX_W), .LEN_W(LEN_W)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (go),
        .reload  (!kill && (b2b || gap_end)),
        .shift   (state == SEND),
        .clear   (kill),
        .pattern (pattern),
        .len     (len_c),
        .msb     (out_bit),
        .last    (last)
    );

    // State, repetition/gap counters and the registered valid/done strobes
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            rep       <= '0;
            gap_r     <= '0;
            gcnt      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= state_n == SEND;
            done      <= kill || fin || (accept && !go);
            if (go) begin
                rep   <= reps;
                gap_r <= gap;
            end else if (last_bit && !fin) begin
                rep <= rep - 1'b1;
            end
            if (to_gap)
                gcnt <= gap_r;
            else if (state == GAP)
                gcnt <= gcnt - 1'b1;
        end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: scoreboard bench with a cycle-timed reference stream model
module tb_serial_pattern_gen;

    typedef struct {
        int cyc;
        bit d;
        bit b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] reps = '0;
    logic [3:0] gap = '0;
    logic       abort = 1'b0;
    logic       out_bit, out_valid, done;

    ev_t  q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   busy_from = 0;
    int   busy_to = -1;
    int   j_a, j_dc, j_c;
    logic exp_ready;

    serial_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .reps        (reps),
        .gap         (gap),
        .abort       (abort),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s cycle=%0d got=%0d required=%0d", n, cyc, act, exp);
    endtask

    task automatic bad(input string n, input int act, input int exp);
        total++;
        $display("FAIL %s cycle=%0d got=%0d required=%0d", n, cyc, act, exp);
    endtask

    // Model: expand the job into its bit stream and done marker, each stamped with its cycle
    task automatic issue(input int p, input int l, input int r, input int g, input int ab, input bit ab_idle);
        int lc, t;
        logic [7:0] pv;
        pv = 8'(p);
        j_a = cyc;
        start_valid = 1'b1;
        pattern = pv;
        len = 4'(l);
        reps = 4'(r);
        gap = 4'(g);
        abort = ab_idle;
        lc = (l > 8) ? 8 : l;
        t = j_a + 1;
        if (lc > 0)
            for (int i = 0; i < r; i++) begin
                for (int b = lc - 1; b >= 0; b--) begin
                    q.push_back('{t, 1'b0, pv[b]});
                    t++;
                end
                if (i < r - 1) t += g;
            end
        q.push_back('{t, 1'b1, 1'b0});
        j_dc = t;
        busy_from = j_a + 1;
        busy_to = t - 1;
        j_c = 0;
        if (t - 1 > j_a) begin
            if (ab > 0) j_c = j_a + ab;
            else if (ab < 0) j_c = j_a + int'($urandom_range(1, t - 1 - j_a));
        end
        @(negedge clk);
        start_valid = 1'b0;
        abort = 1'b0;
    endtask

    // Runs the job to its done cycle, scrambling job inputs and applying a planned abort
    task automatic wait_job();
        while (cyc < j_dc) begin
            if (j_c > 0 && cyc == j_c) begin
                while (q.size() > 0 && q[q.size()-1].cyc > j_c) void'(q.pop_back());
                q.push_back('{j_c + 1, 1'b1, 1'b0});
                busy_to = j_c;
                j_dc = j_c + 1;
                abort = 1'b1;
            end
            @(negedge clk);
            abort = 1'b0;
            pattern = 8'($urandom);
            len = 4'($urandom);
            reps = 4'($urandom);
            gap = 4'($urandom);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_start_ready", int'(start_ready), 1);
    endtask

    // Monitor: ready against the busy window, every output event against the scoreboard
    always @(negedge clk)
        if (rst) begin
            exp_ready = !(cyc >= busy_from && cyc <= busy_to);
            chk("start_ready", int'(start_ready), int'(exp_ready));
            if (!out_valid) chk("out_bit_idle", int'(out_bit), 0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                bad("missing_event", 0, 1);
                void'(q.pop_front());
            end
            if (out_valid || done) begin
                if (q.size() == 0 || q[0].cyc != cyc) bad("unexpected_output", 1, 0);
                else begin
                    chk("valid_done_kind", int'({out_valid, done}), q[0].d ? 1 : 2);
                    if (out_valid) chk("out_bit", int'(out_bit), int'(q[0].b));
                    void'(q.pop_front());
                end
            end
        end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        #12;
        check_reset_outputs();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        issue(8'b0011_0011, 6, 1, 0, 0, 0);
        wait_job();
        issue(8'b0000_1010, 4, 3, 2, 0, 0);
        wait_job();
        issue(8'hFF, 5, 0, 1, 0, 0);
        wait_job();
        issue(8'hFF, 0, 3, 1, 0, 0);
        wait_job();
        issue(8'hA5, 8, 2, 0, 3, 0);
        wait_job();
        issue(8'h3C, 8, 1, 0, 0, 0);
        wait_job();
        issue(8'h96, 9, 1, 0, 0, 0);
        wait_job();
        issue(8'b0000_1010, 4, 2, 3, 0, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        q.delete();
        busy_from = 0;
        busy_to = -1;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        issue(8'b0000_0110, 3, 2, 1, 0, 0);
        wait_job();
        for (int n = 0; n < 150; n++) begin
            issue(int'($urandom), int'($urandom_range(0, 10)),
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? -1 : 0,
                  1'($urandom_range(0, 1)));
            wait_job();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            bad("leftover_event", 0, 1);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
